// File: rtl/beat_sched_pkg.sv
// Shared state encoding and tempo divisors for the song beat scheduler.
package beat_sched_pkg;

  localparam int unsigned DIV_W = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT_IN,
    ST_RUN,
    ST_DONE
  } sched_state_t;

  // Index is the speed_sel code: insane, normal, slower, slowest.
  localparam logic [DIV_W-1:0] SPEED_DIV [4] = '{
    28'd12_500_000,
    28'd25_000_000,
    28'd37_500_000,
    28'd50_000_000
  };

  function automatic logic [DIV_W-1:0] speed_div(input logic [1:0] speed,
                                                 input int unsigned shift);
    return SPEED_DIV[speed] >> shift;
  endfunction

endpackage

// File: rtl/beat_scheduler_if.sv
// Control and pulse bundle between game control / note datapath and the beat scheduler.
interface beat_scheduler_if;
  logic        start;
  logic        abort;
  logic        pause;
  logic [1:0]  speed_sel;
  logic [15:0] song_beats;
  logic        count_tick;
  logic        beat_tick;
  logic        measure_tick;
  logic [15:0] beat_index;
  logic [1:0]  speed_active;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, pause, speed_sel, song_beats,
    input  count_tick, beat_tick, measure_tick, beat_index, speed_active, busy, done
  );

  modport slave (
    input  start, abort, pause, speed_sel, song_beats,
    output count_tick, beat_tick, measure_tick, beat_index, speed_active, busy, done
  );
endinterface

// File: rtl/tick_counter.sv
// Reloadable down-counter: raises tick on an enabled cycle that finds the count at zero.
module tick_counter
  import beat_sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset_b,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [DIV_W-1:0] reload_value,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  assign tick = enable && (count == '0);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load || tick) begin
      count <= reload_value;
    end else if (enable) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/beat_scheduler.sv
// Song tempo sequencer: count-in ticks, then song beats with measure marks; speed
// changes take effect at measure boundaries.
module beat_scheduler
  import beat_sched_pkg::*;
#(
  parameter int unsigned BEATS_PER_MEASURE = 4,
  parameter int unsigned COUNT_IN_BEATS    = 4,
  parameter int unsigned DIV_SHIFT         = 0
) (
  input logic              clock,
  input logic              reset_b,
  beat_scheduler_if.slave  bus
);

  localparam logic [15:0] BPM = 16'(BEATS_PER_MEASURE);
  localparam logic [15:0] CIN = 16'(COUNT_IN_BEATS);

  sched_state_t     state, state_next;
  logic [15:0]      cin_cnt;
  logic [15:0]      song_len;
  logic [15:0]      beat_index;
  logic [15:0]      cur_beat;
  logic [1:0]       speed_active;
  logic             pending;
  logic             count_tick, beat_tick, measure_tick, done;
  logic             enable, tick, start_ok, switch_speed;
  logic             first_in_measure, last_in_measure, final_beat;
  logic [DIV_W-1:0] reload_value;

  assign enable   = (state == ST_COUNT_IN || state == ST_RUN) && !bus.pause;
  assign start_ok = (state == ST_IDLE) && bus.start && (bus.song_beats != '0) && !bus.abort;

  // beat_index lags one edge behind a beat; fold that pending increment back in.
  assign cur_beat         = beat_index + {15'd0, beat_tick && (state == ST_RUN)};
  assign first_in_measure = (cur_beat % BPM) == '0;
  assign last_in_measure  = (cur_beat % BPM) == (BPM - 16'd1);
  assign final_beat       = cur_beat == (song_len - 16'd1);
  assign switch_speed     = (state == ST_RUN) && tick && last_in_measure && pending;
  assign reload_value     = speed_div(start_ok ? bus.speed_sel : speed_active, DIV_SHIFT);

  tick_counter u_tick_counter (
    .clock        (clock),
    .reset_b      (reset_b),
    .enable       (enable),
    .clear        (bus.abort),
    .load         (start_ok),
    .reload_value (reload_value),
    .tick         (tick)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start_ok) state_next = ST_COUNT_IN;
      ST_COUNT_IN: if (tick && cin_cnt == 16'd1) state_next = ST_RUN;
      ST_RUN:      if (tick && final_beat) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    if (bus.abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      cin_cnt      <= '0;
      song_len     <= '0;
      beat_index   <= '0;
      speed_active <= '0;
      pending      <= 1'b0;
      count_tick   <= 1'b0;
      beat_tick    <= 1'b0;
      measure_tick <= 1'b0;
      done         <= 1'b0;
    end else begin
      count_tick   <= tick && (state == ST_COUNT_IN) && !bus.abort;
      beat_tick    <= tick && (state == ST_RUN) && !bus.abort;
      measure_tick <= tick && (state == ST_RUN) && !bus.abort && first_in_measure;
      done         <= (state == ST_DONE) && !bus.abort;
      if (bus.abort) begin
        pending <= 1'b0;
      end else if (start_ok) begin
        speed_active <= bus.speed_sel;
        song_len     <= bus.song_beats;
        cin_cnt      <= CIN;
        beat_index   <= '0;
        pending      <= 1'b0;
      end else begin
        if (state == ST_COUNT_IN && tick) cin_cnt <= cin_cnt - 16'd1;
        if (state == ST_RUN && beat_tick) beat_index <= beat_index + 16'd1;
        // The boundary reload still uses the old divisor; the new one governs the next measure.
        if (switch_speed) begin
          speed_active <= bus.speed_sel;
          pending      <= 1'b0;
        end else begin
          pending <= (state == ST_RUN) && (bus.speed_sel != speed_active);
        end
      end
    end
  end

  assign bus.count_tick   = count_tick;
  assign bus.beat_tick    = beat_tick;
  assign bus.measure_tick = measure_tick;
  assign bus.beat_index   = beat_index;
  assign bus.speed_active = speed_active;
  assign bus.busy         = (state == ST_COUNT_IN) || (state == ST_RUN);
  assign bus.done         = done;

endmodule

// File: tb/tb_beat_scheduler.sv
// Bench for beat_scheduler: directed tempo scenarios plus random control traffic,
// all checked against an event-time reference model.
module tb_beat_scheduler;
  localparam int BPM       = 4;
  localparam int CIN       = 4;
  localparam int DIV_SHIFT = 20;

  logic clock = 1'b0;
  logic reset_b;

  beat_scheduler_if bus();
  beat_scheduler_if bus3();

  beat_scheduler #(.BEATS_PER_MEASURE(BPM), .COUNT_IN_BEATS(CIN), .DIV_SHIFT(DIV_SHIFT)) u_dut (
    .clock(clock), .reset_b(reset_b), .bus(bus));

  beat_scheduler #(.BEATS_PER_MEASURE(3), .COUNT_IN_BEATS(4), .DIV_SHIFT(DIV_SHIFT)) u_dut3 (
    .clock(clock), .reset_b(reset_b), .bus(bus3));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: phase 0 idle, 1 count-in, 2 run, 3 done; m_next is the absolute edge of the next tick.
  int m_phase, m_next, m_cin, m_bn, m_len, m_spd;
  bit m_pend;
  bit e_count, e_beat, e_meas, e_done;
  int e_idx;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", tag, act, exp, cyc);
    end
  endtask

  function automatic int period(input int s);
    int base;
    case (s)
      0:       base = 12_500_000;
      1:       base = 25_000_000;
      2:       base = 37_500_000;
      default: base = 50_000_000;
    endcase
    return (base >> DIV_SHIFT) + 1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_next = 0; m_cin = 0; m_bn = 0; m_len = 0; m_spd = 0; m_pend = 0;
    e_count = 0; e_beat = 0; e_meas = 0; e_done = 0; e_idx = 0;
  endtask

  task automatic model_step();
    bit was_beat = e_beat;
    int ph = m_phase;
    bit sw = 0;
    bit tk = 0;
    e_count = 0; e_beat = 0; e_meas = 0; e_done = 0;
    if (bus.abort) begin
      m_phase = 0;
      m_pend  = 0;
      return;
    end
    if (ph == 2 && was_beat) e_idx++;
    if (ph == 1 || ph == 2) begin
      if (bus.pause) m_next++;
      else if (cyc == m_next) tk = 1;
    end
    case (ph)
      0: if (bus.start && bus.song_beats != 0) begin
        m_phase = 1; m_spd = int'(bus.speed_sel); m_len = int'(bus.song_beats);
        m_cin = CIN; e_idx = 0; m_bn = 0; m_next = cyc + period(m_spd);
      end
      1: if (tk) begin
        e_count = 1; m_cin--; m_next = cyc + period(m_spd);
        if (m_cin == 0) m_phase = 2;
      end
      2: if (tk) begin
        e_beat = 1; e_meas = (m_bn % BPM == 0); m_next = cyc + period(m_spd);
        if (m_bn % BPM == BPM - 1 && m_pend) begin m_spd = int'(bus.speed_sel); sw = 1; end
        if (m_bn == m_len - 1) m_phase = 3;
        m_bn++;
      end
      default: begin e_done = 1; m_phase = 0; end
    endcase
    m_pend = (ph == 2) && !sw && (int'(bus.speed_sel) != m_spd);
  endtask

  task automatic compare_all();
    chk("count_tick",   int'(bus.count_tick),   int'(e_count));
    chk("beat_tick",    int'(bus.beat_tick),    int'(e_beat));
    chk("measure_tick", int'(bus.measure_tick), int'(e_meas));
    chk("done",         int'(bus.done),         int'(e_done));
    chk("beat_index",   int'(bus.beat_index),   e_idx);
    chk("speed_active", int'(bus.speed_active), m_spd);
    chk("busy",         int'(bus.busy),         int'(m_phase == 1 || m_phase == 2));
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic start_song(input int spd, input int len);
    bus.speed_sel = 2'(spd); bus.song_beats = 16'(len); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_beat(input string tag, output int e);
    bit found = 0;
    e = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (bus.beat_tick) begin found = 1; e = cyc; end
    end
    chk(tag, int'(found), 1);
  endtask

  task automatic finish_song(input string tag);
    bit found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step();
      if (bus.done) found = 1;
    end
    chk(tag, int'(found), 1);
  endtask

  task automatic count_events(input int n, output int ev);
    ev = 0;
    for (int k = 0; k < n; k++) begin
      step();
      ev += int'(bus.count_tick) + int'(bus.beat_tick) + int'(bus.done);
    end
  endtask

  initial begin
    int e0, ev, pause_left, done_e;
    int b[8];
    int ct_q[$], bt_q[$], ms_q[$], ix_q[$];
    bit got;

    reset_b = 1'b0;
    bus.start = 0; bus.abort = 0; bus.pause = 0; bus.speed_sel = 0; bus.song_beats = 0;
    bus3.start = 0; bus3.abort = 0; bus3.pause = 0; bus3.speed_sel = 0; bus3.song_beats = 0;
    model_reset();
    repeat (2) @(negedge clock);
    compare_all();
    reset_b = 1'b1;

    // Basic run: speed normal, 8 beats.
    start_song(1, 8);
    e0 = cyc; got = 0; done_e = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      step();
      if (bus.count_tick) ct_q.push_back(cyc - e0);
      if (bus.beat_tick) begin bt_q.push_back(cyc - e0); ix_q.push_back(int'(bus.beat_index)); end
      if (bus.measure_tick) ms_q.push_back(cyc - e0);
      if (bus.done) begin got = 1; done_e = cyc - e0; end
    end
    chk("s1_count_ticks", ct_q.size(), 4);
    for (int k = 0; k < 4; k++) chk("s1_count_time", (k < ct_q.size()) ? ct_q[k] : -1, 24 * (k + 1));
    chk("s1_beats", bt_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("s1_beat_time", (k < bt_q.size()) ? bt_q[k] : -1, 120 + 24 * k);
      chk("s1_beat_index", (k < ix_q.size()) ? ix_q[k] : -1, k);
    end
    chk("s1_measures", ms_q.size(), 2);
    chk("s1_measure0", (ms_q.size() > 0) ? ms_q[0] : -1, 120);
    chk("s1_measure1", (ms_q.size() > 1) ? ms_q[1] : -1, 216);
    chk("s1_done_time", done_e, 289);
    step();
    chk("s1_busy_after", int'(bus.busy), 0);

    // Speed change slowest -> insane requested during beat 1.
    start_song(3, 12);
    wait_beat("s2_b0", b[0]);
    wait_beat("s2_b1", b[1]);
    bus.speed_sel = 2'd0;
    for (int n = 2; n < 7; n++) begin
      wait_beat("s2_beat_wait", b[n]);
      if (n == 2) chk("s2_speed_b2", int'(bus.speed_active), 3);
      if (n == 3) chk("s2_speed_b3", int'(bus.speed_active), 0);
    end
    chk("s2_gap12", b[2] - b[1], 48);
    chk("s2_gap23", b[3] - b[2], 48);
    chk("s2_gap34", b[4] - b[3], 48);
    chk("s2_gap45", b[5] - b[4], 12);
    chk("s2_gap56", b[6] - b[5], 12);
    finish_song("s2_done");

    // Pause mid-count, ignored start while running, pause held across a zero count.
    bus.speed_sel = 2'd1;
    start_song(1, 6);
    wait_beat("s3_b0", b[0]);
    bus.start = 1'b1; bus.song_beats = 16'd3;
    step();
    bus.start = 1'b0;
    wait_beat("s3_b1", b[1]);
    repeat (18) step();
    bus.pause = 1'b1;
    repeat (100) step();
    bus.pause = 1'b0;
    wait_beat("s3_b2", b[2]);
    chk("s3_pause_delay", b[2] - b[1], 124);
    chk("s3_index_b2", int'(bus.beat_index), 2);
    repeat (23) step();
    bus.pause = 1'b1;
    count_events(30, ev);
    chk("s3_no_tick_paused", ev, 0);
    bus.pause = 1'b0;
    wait_beat("s3_b3", b[3]);
    chk("s3_zero_hold", b[3] - b[2], 54);
    chk("s3_index_b3", int'(bus.beat_index), 3);
    finish_song("s3_done");

    // Zero-length song is ignored.
    start_song(0, 0);
    chk("s4_zero_busy", int'(bus.busy), 0);
    count_events(30, ev);
    chk("s4_zero_events", ev, 0);

    // Abort in count-in, abort in run, async reset in run.
    start_song(0, 4);
    repeat (20) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("s5_abort_cin_busy", int'(bus.busy), 0);
    count_events(60, ev);
    chk("s5_abort_cin_quiet", ev, 0);
    start_song(0, 10);
    wait_beat("s5_run_b0", b[0]);
    wait_beat("s5_run_b1", b[1]);
    repeat (3) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("s5_abort_run_busy", int'(bus.busy), 0);
    count_events(60, ev);
    chk("s5_abort_run_quiet", ev, 0);
    start_song(2, 10);
    wait_beat("s5_rst_b0", b[0]);
    wait_beat("s5_rst_b1", b[1]);
    repeat (2) step();
    #2 reset_b = 1'b0;
    #1;
    chk("s5_rst_busy", int'(bus.busy), 0);
    chk("s5_rst_index", int'(bus.beat_index), 0);
    chk("s5_rst_speed", int'(bus.speed_active), 0);
    chk("s5_rst_beat", int'(bus.beat_tick), 0);
    chk("s5_rst_done", int'(bus.done), 0);
    model_reset();
    #1 reset_b = 1'b1;
    count_events(40, ev);
    chk("s5_rst_quiet", ev, 0);

    // One-beat song with three beats per measure.
    bus3.speed_sel = 2'd0; bus3.song_beats = 16'd1; bus3.start = 1'b1;
    step();
    bus3.start = 1'b0;
    e0 = cyc; got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      step();
      if (bus3.beat_tick) got = 1;
    end
    chk("s6_beat_seen", int'(got), 1);
    chk("s6_beat_time", cyc - e0, 60);
    chk("s6_measure", int'(bus3.measure_tick), 1);
    chk("s6_index", int'(bus3.beat_index), 0);
    step();
    chk("s6_done", int'(bus3.done), 1);
    ev = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      ev += int'(bus3.beat_tick) + int'(bus3.done) + int'(bus3.busy);
    end
    chk("s6_quiet", ev, 0);

    // Random control traffic against the model.
    pause_left = 0;
    bus.song_beats = 16'd5;
    for (int i = 0; i < 6000; i++) begin
      bus.start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) bus.song_beats = 16'($urandom_range(0, 9));
      bus.abort = ($urandom_range(0, 999) == 0);
      if (pause_left > 0) pause_left--;
      else if ($urandom_range(0, 59) == 0) pause_left = $urandom_range(1, 40);
      bus.pause = (pause_left > 0);
      if ($urandom_range(0, 39) == 0) bus.speed_sel = 2'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
